// File: rtl/button_bank.sv
// rtl/button_bank.sv - N-channel push-button synchroniser, debouncer and press/long/repeat classifier
`timescale 1ns/1ps
module button_bank #(
    parameter int NUM_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int REPEAT_CYCLES     = 10000000,
    parameter bit REPEAT_EN         = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic                   enable,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_long,
    output logic [NUM_BUTTONS-1:0] btn_repeat,
    output logic                   any_press
);
    localparam int DCW  = $clog2(DEBOUNCE_CYCLES);
    localparam int HMAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int HCW  = $clog2(HMAX);

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        logic           sync1_q, sync2_q;
        state_t         state_q, state_d;
        logic [DCW-1:0] dcnt_q, dcnt_d;
        logic [HCW-1:0] hcnt_q, hcnt_d;
        logic           long_done_q, long_done_d;
        logic           level_q, level_d;
        logic           press_q, press_d;
        logic           release_q, release_d;
        logic           long_q, long_d;
        logic           repeat_q, repeat_d;

        always_comb begin
            state_d     = state_q;
            dcnt_d      = dcnt_q;
            hcnt_d      = hcnt_q;
            long_done_d = long_done_q;
            level_d     = level_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            long_d      = 1'b0;
            repeat_d    = 1'b0;
            if (!enable) begin
                state_d     = IDLE;
                dcnt_d      = '0;
                hcnt_d      = '0;
                long_done_d = 1'b0;
                level_d     = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sync2_q) begin
                            state_d = DB_PRESS;
                            dcnt_d  = '0;
                        end
                    end
                    DB_PRESS: begin
                        if (!sync2_q) begin
                            state_d = IDLE;
                        end else if (dcnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
                            state_d     = HELD;
                            level_d     = 1'b1;
                            press_d     = 1'b1;
                            hcnt_d      = '0;
                            long_done_d = 1'b0;
                        end else begin
                            dcnt_d = dcnt_q + DCW'(1);
                        end
                    end
                    HELD: begin
                        // Hold timing still advances on the edge that leaves for DB_RELEASE.
                        hcnt_d = hcnt_q + HCW'(1);
                        if (!long_done_q) begin
                            if (hcnt_q == HCW'(LONG_PRESS_CYCLES - 1)) begin
                                long_d      = 1'b1;
                                long_done_d = 1'b1;
                                hcnt_d      = '0;
                            end
                        end else if (REPEAT_EN) begin
                            if (hcnt_q == HCW'(REPEAT_CYCLES - 1)) begin
                                repeat_d = 1'b1;
                                hcnt_d   = '0;
                            end
                        end else begin
                            hcnt_d = hcnt_q;
                        end
                        if (!sync2_q) begin
                            state_d = DB_RELEASE;
                            dcnt_d  = '0;
                        end
                    end
                    DB_RELEASE: begin
                        if (sync2_q) begin
                            state_d = HELD;
                        end else if (dcnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
                            state_d   = IDLE;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            dcnt_d = dcnt_q + DCW'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                sync1_q     <= 1'b0;
                sync2_q     <= 1'b0;
                state_q     <= IDLE;
                dcnt_q      <= '0;
                hcnt_q      <= '0;
                long_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
                repeat_q    <= 1'b0;
            end else begin
                sync1_q     <= btn_raw[i];
                sync2_q     <= sync1_q;
                state_q     <= state_d;
                dcnt_q      <= dcnt_d;
                hcnt_q      <= hcnt_d;
                long_done_q <= long_done_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                long_q      <= long_d;
                repeat_q    <= repeat_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_long[i]    = long_q;
        assign btn_repeat[i]  = repeat_q;
    end

    logic any_press_q, any_press_d;

    always_comb begin
        any_press_d = enable && (|btn_press);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;
endmodule

// File: tb/tb_button_bank.sv
// tb/tb_button_bank.sv - self-checking bench for button_bank against a run-length reference model
`timescale 1ns/1ps
module tb_button_bank;
    localparam int N  = 4;
    localparam int DB = 4;
    localparam int LP = 20;
    localparam int RP = 8;
    localparam int VW = 5 * N + 1;

    logic         clk     = 1'b0;
    logic         reset_b = 1'b1;
    logic         enable  = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] lvl, prs, rls, lng, rpt;
    logic         anyp;
    logic [N-1:0] lvl_nr, prs_nr, rls_nr, lng_nr, rpt_nr;
    logic         anyp_nr;
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_bank #(.NUM_BUTTONS(N), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP),
                  .REPEAT_CYCLES(RP), .REPEAT_EN(1'b1)) dut (
        .clk(clk), .reset_b(reset_b), .enable(enable), .btn_raw(btn_raw),
        .btn_level(lvl), .btn_press(prs), .btn_release(rls), .btn_long(lng),
        .btn_repeat(rpt), .any_press(anyp));

    button_bank #(.NUM_BUTTONS(N), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP),
                  .REPEAT_CYCLES(RP), .REPEAT_EN(1'b0)) dut_nr (
        .clk(clk), .reset_b(reset_b), .enable(enable), .btn_raw(btn_raw),
        .btn_level(lvl_nr), .btn_press(prs_nr), .btn_release(rls_nr), .btn_long(lng_nr),
        .btn_repeat(rpt_nr), .any_press(anyp_nr));

    // Reference: a level flips once the synchronised input has disagreed with it for DB+1
    // consecutive edges; hold time counts only edges spent steadily held.
    typedef struct packed {
        logic level;
        logic prs;
        logic rls;
        logic lng;
        logic rep;
        int   run;
        int   act;
    } ch_t;

    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_level = '0;
    logic [N-1:0] e_press = '0, e_release = '0, e_long = '0, e_rep = '0;
    logic         e_any = 1'b0;
    int           m_run [N];
    int           m_act [N];
    ch_t          nxt   [N];

    function automatic ch_t model_step(logic level, int run, int act, logic sync);
        ch_t r;
        r       = '0;
        r.level = level;
        r.act   = act;
        r.run   = (sync != level) ? run + 1 : 0;
        if (level && run == 0) begin
            r.act = act + 1;
            r.lng = (r.act == LP);
            r.rep = (r.act > LP) && ((r.act - LP) % RP == 0);
        end
        if (r.run == DB + 1) begin
            r.level = ~level;
            r.run   = 0;
            r.act   = 0;
            r.prs   = ~level;
            r.rls   = level;
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) nxt[i] = model_step(m_level[i], m_run[i], m_act[i], m_s2[i]);
    end

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m_s1 <= '0; m_s2 <= '0; m_level <= '0;
            e_press <= '0; e_release <= '0; e_long <= '0; e_rep <= '0; e_any <= 1'b0;
            for (int i = 0; i < N; i++) begin
                m_run[i] <= 0;
                m_act[i] <= 0;
            end
        end else begin
            m_s1  <= btn_raw;
            m_s2  <= m_s1;
            e_any <= enable && (e_press != '0);
            for (int i = 0; i < N; i++) begin
                m_level[i]   <= enable && nxt[i].level;
                m_run[i]     <= enable ? nxt[i].run : 0;
                m_act[i]     <= enable ? nxt[i].act : 0;
                e_press[i]   <= enable && nxt[i].prs;
                e_release[i] <= enable && nxt[i].rls;
                e_long[i]    <= enable && nxt[i].lng;
                e_rep[i]     <= enable && nxt[i].rep;
            end
        end
    end

    wire [VW-1:0] dut_vec    = {lvl, prs, rls, lng, rpt, anyp};
    wire [VW-1:0] nr_vec     = {lvl_nr, prs_nr, rls_nr, lng_nr, rpt_nr, anyp_nr};
    wire [VW-1:0] exp_vec    = {m_level, e_press, e_release, e_long, e_rep, e_any};
    wire [VW-1:0] exp_nr_vec = {m_level, e_press, e_release, e_long, {N{1'b0}}, e_any};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset_b = 1'b0;
        #2;
        if (dut_vec !== {VW{1'b0}} || nr_vec !== {VW{1'b0}}) begin
            errors++; $display("FAIL reset_async dut=%h/%h required=0", dut_vec, nr_vec);
        end
        checks++;
        repeat (3) tick();
        reset_b = 1'b1;
        enable  = 1'b1;
        repeat (5) begin
            tick();
            if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                errors++; $display("FAIL reset_idle cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
            end
            checks++;
        end
    endtask

    task automatic test_clean_press();
        int k, kr, pe, re, np, nrl, nl;
        pe = -1; re = -1; np = 0; nrl = 0; nl = 0;
        btn_raw[0] = 1'b1;
        k = cyc + 1;
        for (int t = 0; t < 27; t++) begin
            if (t == 15) begin
                btn_raw[0] = 1'b0;
                kr = cyc + 1;
            end
            tick();
            if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                errors++; $display("FAIL clean_press cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
            end
            checks++;
            if (prs[0]) begin np++; pe = cyc; end
            if (rls[0]) begin nrl++; re = cyc; end
            if (lng[0]) nl++;
        end
        if (np != 1 || pe - k != DB + 2) begin
            errors++; $display("FAIL clean_press_latency count=%0d offset=%0d required 1/%0d", np, pe - k, DB + 2);
        end
        checks++;
        if (nrl != 1 || re - kr != DB + 2) begin
            errors++; $display("FAIL clean_release_latency count=%0d offset=%0d required 1/%0d", nrl, re - kr, DB + 2);
        end
        checks++;
        if (nl != 0) begin
            errors++; $display("FAIL clean_no_long count=%0d required 0", nl);
        end
        checks++;
    endtask

    task automatic test_bounce();
        int np, nrl, pe, re, s, nb;
        np = 0; nrl = 0; pe = -1; re = -1;
        for (int phase = 0; phase < 2; phase++) begin
            nb = $urandom_range(2, 4);
            for (int b = 0; b < nb; b++) begin
                btn_raw[1] = (phase == 0);
                repeat ((b == 0) ? 1 : $urandom_range(1, DB)) begin
                    tick();
                    if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                        errors++; $display("FAIL bounce cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
                    end
                    checks++;
                    if (prs[1]) begin np++; pe = cyc; end
                    if (rls[1]) begin nrl++; re = cyc; end
                end
                btn_raw[1] = (phase != 0);
                repeat ((b == 0) ? 1 : $urandom_range(1, 3)) begin
                    tick();
                    if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                        errors++; $display("FAIL bounce cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
                    end
                    checks++;
                    if (prs[1]) begin np++; pe = cyc; end
                    if (rls[1]) begin nrl++; re = cyc; end
                end
            end
            btn_raw[1] = (phase == 0);
            s = cyc + 1;
            repeat (12) begin
                tick();
                if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                    errors++; $display("FAIL bounce_steady cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
                end
                checks++;
                if (prs[1]) begin np++; pe = cyc; end
                if (rls[1]) begin nrl++; re = cyc; end
            end
            if (phase == 0 && (np != 1 || pe - s != DB + 2)) begin
                errors++; $display("FAIL bounce_press count=%0d offset=%0d required 1/%0d", np, pe - s, DB + 2);
            end
            if (phase == 1 && (nrl != 1 || re - s != DB + 2)) begin
                errors++; $display("FAIL bounce_release count=%0d offset=%0d required 1/%0d", nrl, re - s, DB + 2);
            end
            checks++;
        end
    endtask

    task automatic test_long_repeat();
        int pe, t, nlg, lo, nrp, lo_nr, nrp_nr;
        pe = -1; t = 0; nlg = 0; lo = -1; nrp = 0; lo_nr = -1; nrp_nr = 0;
        btn_raw[2] = 1'b1;
        while (pe < 0 && t < 20) begin
            tick();
            if (prs[2]) pe = cyc;
            t++;
        end
        if (pe < 0) begin
            errors++; $display("FAIL long_press_seen timeout after %0d cycles", t);
        end
        checks++;
        repeat (60) begin
            tick();
            if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                errors++; $display("FAIL long_repeat cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
            end
            checks++;
            if (lng[2]) begin nlg++; lo = cyc - pe; end
            if (lng_nr[2]) lo_nr = cyc - pe;
            if (rpt_nr[2]) nrp_nr++;
            if (rpt[2]) begin
                nrp++;
                if (cyc - pe != LP + RP * nrp) begin
                    errors++; $display("FAIL repeat_offset got=%0d required=%0d", cyc - pe, LP + RP * nrp);
                end
                checks++;
            end
        end
        if (nlg != 1 || lo != LP || lo_nr != LP) begin
            errors++; $display("FAIL long_offset count=%0d offset=%0d/%0d required 1/%0d", nlg, lo, lo_nr, LP);
        end
        checks++;
        if (nrp != (60 - LP) / RP || nrp_nr != 0) begin
            errors++; $display("FAIL repeat_count got=%0d/%0d required %0d/0", nrp, nrp_nr, (60 - LP) / RP);
        end
        checks++;
        btn_raw[2] = 1'b0;
        repeat (15) begin
            tick();
            if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                errors++; $display("FAIL long_drain cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
            end
            checks++;
        end
    endtask

    task automatic test_glitch();
        int pe, t, h, n, lo, nrl, lowlvl;
        pe = -1; t = 0; lo = -1; nrl = 0; lowlvl = 0;
        h = $urandom_range(2, 8);
        n = $urandom_range(1, DB);
        btn_raw[2] = 1'b1;
        while (pe < 0 && t < 20) begin
            tick();
            if (prs[2]) pe = cyc;
            t++;
        end
        for (int i = 1; i <= 40; i++) begin
            if (i == h + 1) btn_raw[2] = 1'b0;
            if (i == h + 1 + n) btn_raw[2] = 1'b1;
            tick();
            if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                errors++; $display("FAIL glitch cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
            end
            checks++;
            if (!lvl[2]) lowlvl++;
            if (rls[2]) nrl++;
            if (lng[2] && lo < 0) lo = cyc - pe;
        end
        if (pe < 0 || lowlvl != 0 || nrl != 0) begin
            errors++; $display("FAIL glitch_level press=%0d low_cycles=%0d releases=%0d required 0/0", pe, lowlvl, nrl);
        end
        checks++;
        if (lo != LP + n) begin
            errors++; $display("FAIL glitch_long_delay offset=%0d required=%0d", lo, LP + n);
        end
        checks++;
        btn_raw[2] = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_simultaneous();
        int k, pe, ae, bad;
        pe = -1; ae = -1; bad = 0;
        btn_raw = '1;
        k = cyc + 1;
        repeat (10) begin
            tick();
            if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                errors++; $display("FAIL simultaneous cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
            end
            checks++;
            if (prs != '0) begin
                pe = cyc;
                if (prs !== 4'hF) bad++;
            end
            if (anyp) ae = cyc;
        end
        if (bad != 0 || pe - k != DB + 2 || ae != pe + 1) begin
            errors++; $display("FAIL simultaneous_timing split=%0d press_off=%0d any_at=%0d required 0/%0d/%0d", bad, pe - k, ae, DB + 2, pe + 1);
        end
        checks++;
        btn_raw = '0;
        repeat (15) tick();
    endtask

    task automatic test_reset_enable();
        int np, pe, t, e;
        np = 0; pe = -1; t = 0;
        btn_raw[3] = 1'b1;
        repeat (10) tick();
        btn_raw[0] = 1'b1;
        repeat (3) tick();
        #2 reset_b = 1'b0;
        #1;
        if (dut_vec !== {VW{1'b0}} || nr_vec !== {VW{1'b0}}) begin
            errors++; $display("FAIL reset_mid_event dut=%h/%h required=0", dut_vec, nr_vec);
        end
        checks++;
        btn_raw = '0;
        repeat (2) tick();
        reset_b = 1'b1;
        repeat (15) begin
            tick();
            if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                errors++; $display("FAIL reset_after cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
            end
            checks++;
            if (prs != '0) np++;
        end
        if (np != 0) begin
            errors++; $display("FAIL reset_no_press count=%0d required 0", np);
        end
        checks++;
        btn_raw[0] = 1'b1;
        while (pe < 0 && t < 20) begin
            tick();
            if (prs[0]) pe = cyc;
            t++;
        end
        repeat (3) tick();
        enable = 1'b0;
        tick();
        if (lvl[0] !== 1'b0 || dut_vec !== {VW{1'b0}} || nr_vec !== {VW{1'b0}}) begin
            errors++; $display("FAIL enable_off pressed_at=%0d dut=%h/%h required=0", pe, dut_vec, nr_vec);
        end
        checks++;
        repeat (3) tick();
        enable = 1'b1;
        e = cyc + 1;
        np = 0; pe = -1;
        repeat (10) begin
            tick();
            if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                errors++; $display("FAIL enable_on cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
            end
            checks++;
            if (prs[0]) begin np++; pe = cyc; end
        end
        if (np != 1 || pe - e != DB) begin
            errors++; $display("FAIL enable_fresh_press count=%0d offset=%0d required 1/%0d", np, pe - e, DB);
        end
        checks++;
        btn_raw = '0;
        repeat (15) tick();
    endtask

    task automatic test_random();
        int hold [N];
        int off;
        off = 0;
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 30);
        repeat (900) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB) : $urandom_range(DB + 1, 45);
                end
            end
            if (off > 0) begin
                off--;
                if (off == 0) enable = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                enable = 1'b0;
                off = $urandom_range(1, 5);
            end
            tick();
            if (dut_vec !== exp_vec || nr_vec !== exp_nr_vec) begin
                errors++; $display("FAIL random cyc=%0d dut=%h/%h exp=%h/%h", cyc, dut_vec, nr_vec, exp_vec, exp_nr_vec);
            end
            checks++;
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_glitch();
        test_simultaneous();
        test_reset_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
